// File: rtl/if_fetch_queue.sv
// Fetch-to-decode decoupling FIFO carrying {pc, pc+4, instr}; single-cycle flush on redirect.
// Optional combinational empty-queue bypass enabled by defining IFQ_BYPASS_EN.
module if_fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [XLEN-1:0]            enq_pc,
  input  logic [XLEN-1:0]            enq_pc_plus_4,
  input  logic [XLEN-1:0]            enq_instr,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [XLEN-1:0]            deq_pc,
  output logic [XLEN-1:0]            deq_pc_plus_4,
  output logic [XLEN-1:0]            deq_instr,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [PW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [XLEN-1:0] r_pc4   [DEPTH];
  logic [XLEN-1:0] r_instr [DEPTH];

  logic w_empty, w_full, w_live, w_byp, w_enq, w_deq, w_wr, w_rd;

  assign w_empty = (r_rd_ptr == r_wr_ptr);
  assign w_full  = (r_rd_ptr[IW-1:0] == r_wr_ptr[IW-1:0]) && (r_rd_ptr[IW] != r_wr_ptr[IW]);
  assign w_live  = !flush && !rst;

`ifdef IFQ_BYPASS_EN
  assign w_byp = w_empty && enq_valid;
`else
  assign w_byp = 1'b0;
`endif

  // enq_ready deliberately ignores deq_ready: no comb path decode -> fetch
  assign enq_ready = !w_full && w_live;
  assign deq_valid = w_live && (!w_empty || w_byp);
  assign count     = r_wr_ptr - r_rd_ptr;

  assign w_enq = enq_valid && enq_ready;
  assign w_deq = deq_valid && deq_ready;
  // a bypassed entry consumed in the same cycle never touches storage
  assign w_wr  = w_enq && !(w_byp && deq_ready);
  assign w_rd  = w_deq && !w_empty;

  always_comb begin
    deq_pc        = '0;
    deq_pc_plus_4 = '0;
    deq_instr     = NOP;
    if (deq_valid) begin
      if (w_empty) begin
        deq_pc        = enq_pc;
        deq_pc_plus_4 = enq_pc_plus_4;
        deq_instr     = enq_instr;
      end else begin
        deq_pc        = r_pc[r_rd_ptr[IW-1:0]];
        deq_pc_plus_4 = r_pc4[r_rd_ptr[IW-1:0]];
        deq_instr     = r_instr[r_rd_ptr[IW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // storage is intentionally not reset or cleared on flush
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_pc[r_wr_ptr[IW-1:0]]    <= enq_pc;
      r_pc4[r_wr_ptr[IW-1:0]]   <= enq_pc_plus_4;
      r_instr[r_wr_ptr[IW-1:0]] <= enq_instr;
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: stimulus records accepted entries, a negedge
// monitor compares handshake, occupancy and head contents against a queue model.
module tb_if_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ent_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            enq_valid = 1'b0;
  logic            enq_ready;
  logic [XLEN-1:0] enq_pc = '0, enq_pc_plus_4 = '0, enq_instr = '0;
  logic            deq_valid;
  logic            deq_ready = 1'b0;
  logic [XLEN-1:0] deq_pc, deq_pc_plus_4, deq_instr;
  logic [CW-1:0]   count;

  if_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_pc(enq_pc), .enq_pc_plus_4(enq_pc_plus_4), .enq_instr(enq_instr),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_pc_plus_4(deq_pc_plus_4), .deq_instr(deq_instr),
    .count(count)
  );

  always #5 clk = ~clk;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  ent_t sb[$];          // entries currently held by the queue, head first
  ent_t pend;           // entry offered this cycle that the queue will accept
  bit   pend_v = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   seen_40 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: sampled mid-cycle, inputs stable since posedge+1
  initial begin
    forever begin
      @(negedge clk);
      begin
        bit   live, exp_vld, fire;
        ent_t h;
        live    = !rst && !flush;
        exp_vld = live && (sb.size() > 0 || (BYP && enq_valid));
        chk("enq_ready", 32'(enq_ready), 32'(live && sb.size() < DEPTH));
        chk("deq_valid", 32'(deq_valid), 32'(exp_vld));
        chk("count",     32'(count),     32'(sb.size()));
        fire = exp_vld && deq_ready;
        if (exp_vld) begin
          if (sb.size() > 0) h = sb[0];
          else begin
            h.pc = enq_pc; h.pc4 = enq_pc_plus_4; h.instr = enq_instr;
          end
          if (fire) begin
            chk("deq_pc",    deq_pc,        h.pc);
            chk("deq_pc4",   deq_pc_plus_4, h.pc4);
            chk("deq_instr", deq_instr,     h.instr);
            if (deq_pc === 32'h40) seen_40++;
            if (sb.size() > 0) void'(sb.pop_front());
            else pend_v = 1'b0;   // bypassed straight through
          end
        end else begin
          chk("idle_instr", deq_instr, NOP);
          chk("idle_pc",    deq_pc,    32'h0);
          chk("idle_pc4",   deq_pc_plus_4, 32'h0);
        end
        if (rst || flush) sb.delete();
        if (pend_v) begin
          sb.push_back(pend);
          pend_v = 1'b0;
        end
      end
    end
  end

  // drive one cycle of stimulus; record the entry if the queue will accept it
  task automatic cyc(input bit ev, input logic [31:0] pc, input logic [31:0] ins,
                     input bit dr, input bit fl, input bit rs);
    @(posedge clk);
    #1;
    rst = rs; flush = fl; enq_valid = ev; deq_ready = dr;
    enq_pc = pc; enq_pc_plus_4 = pc + 32'd4; enq_instr = ins;
    pend_v = 1'b0;
    if (ev && !fl && !rs && sb.size() < DEPTH) begin
      pend.pc = pc; pend.pc4 = pc + 32'd4; pend.instr = ins;
      pend_v = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] pc;
    // reset
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    // single entry, deq_ready held
    cyc(1, 32'h0, 32'h0050_0093, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    // fill with decode stalled, 5th offer dropped, then drain
    for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 32'h1000_0000 + 32'(i), 0, 0, 0);
    cyc(1, 32'h10, 32'hdead_beef, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 1, 0, 0);
    // back-to-back streaming across pointer wrap
    for (int i = 0; i < 10; i++) cyc(1, 32'h100 + 32'(i * 4), 32'h2000_0000 + 32'(i), 1, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 0, 0);
    // flush with 3 queued while 0x40 is offered
    for (int i = 0; i < 3; i++) cyc(1, 32'h200 + 32'(i * 4), 32'h3000_0000 + 32'(i), 0, 0, 0);
    cyc(1, 32'h40, 32'h4000_0040, 0, 1, 0);
    cyc(1, 32'h80, 32'h4000_0080, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0);
    // reset mid-stream with 2 queued, then flush+rst together
    for (int i = 0; i < 2; i++) cyc(1, 32'h300 + 32'(i * 4), 32'h5000_0000 + 32'(i), 0, 0, 0);
    repeat (2) cyc(1, 32'h400, 32'h6000_0000, 1, 0, 1);
    cyc(1, 32'h404, 32'h6000_0004, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    // randomized traffic
    pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      bit ev, dr, fl, rs;
      ev = ($urandom_range(0, 9) < 7);
      dr = ($urandom_range(0, 9) < 6);
      fl = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 99) == 0);
      cyc(ev, pc, $urandom, dr, fl, rs);
      if (ev) pc = pc + 32'd4;
    end
    repeat (6) cyc(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #1;
    chk("pc40_never_dequeued", 32'(seen_40), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
